instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Producer end of the instruction interface: generates the 32-bit instruction stream that the decode stage consumes.
- Issues word-aligned fetch requests to instruction memory and buffers in-order responses in a small FIFO.
- Presents instruction+PC to decode under a valid/ready handshake.
- Handles jump/branch redirects: flushes buffered words and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC of first fetch after reset (word-aligned).
- DEPTH, 2, FIFO entries; also the max outstanding+buffered words (power of two, >=2).
- ADDR_W, 32, address/PC width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  ADDR_W  fetch address (bits[1:0]=0).
- imem_rsp_valid  in  1  response data valid; responses in request order, latency >=1 cycle.
- imem_rsp_data  in  32  fetched instruction word.
- redirect_valid  in  1  taken jump/branch from execute (jump_enable path).
- redirect_target  in  ADDR_W  new PC; bits[1:0] ignored (forced 0).
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes this cycle.
- instruction  out  32  instruction word to decode.
- inst_pc  out  ADDR_W  PC of instruction.

Behaviour:
- Reset (rst_n=0 at posedge): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0; imem_req_valid=0, inst_valid=0, instruction=0, inst_pc=0. Outputs stay at reset values for the reset cycle. Reset mid-operation aborts everything; responses arriving after reset for pre-reset requests are the memory's responsibility (memory is reset with the same rst_n).
- Credit: imem_req_valid=1 iff not in reset, redirect_valid=0, and (outstanding + fifo_count) < DEPTH.
- Request fires when imem_req_valid & imem_req_ready:
  - imem_addr=fetch_pc.
  - fetch_pc += 4 (wraps modulo 2^ADDR_W).
  - outstanding += 1.
- Response handling, when imem_rsp_valid:
  - drop>0: word discarded, drop -= 1, outstanding -= 1.
  - Otherwise: word and its PC pushed to FIFO, outstanding -= 1.
  - Response PC is tracked in a parallel PC queue; PC queue and FIFO are written together.
- Output: inst_valid = FIFO non-empty; instruction/inst_pc = FIFO head, registered, with no combinational path from memory. Pop when inst_valid & inst_ready.
- Min latency: request accepted at cycle t, response at t+L, inst_valid at t+L+1.
- Redirect (redirect_valid=1 at posedge):
  - FIFO cleared; inst_valid=0 next cycle; a concurrent pop is ignored.
  - fetch_pc = {redirect_target[ADDR_W-1:2],2'b00}.
  - drop = outstanding after including any request/response in the same cycle. A request accepted in the redirect cycle cannot occur because req_valid=0. A response in the same cycle is dropped (counted against the old outstanding).
  - First request to the target is issued the following cycle.
- Back-to-back redirects: latest target wins; drop accumulates correctly.
- FIFO full with inst_ready=0: no new requests (credit guarantees no overflow). Push and pop in the same cycle on a full FIFO are legal.
- Credit invariant: outstanding + fifo_count <= DEPTH at all times. Violation is an assertion error in simulation.

Optional Feature:
- IFETCH_PERF_EN defined: adds ports perf_fetched (out, 32) and perf_dropped (out, 32).
  - perf_fetched counts responses pushed to the FIFO.
  - perf_dropped counts responses discarded plus FIFO entries flushed by redirect.
  - Both are 0 on reset and wrap at 2^32.
- Not defined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package (with decode's constants):
  - opcode localparams: OP, OP_IMM, LOAD, STORE, JAL, BRANCH, SYSTEM.
  - NOP encoding 32'h0000_0013.
  - default RESET_PC.
  - instruction width 32.
- One sub-module: instr_fetch_fifo, a parameterised DEPTH x (32+ADDR_W) synchronous FIFO with push/pop/clear/count and synchronous active-low reset.

Test Plan:
- Reset release, memory latency 1, inst_ready=1: addresses 0,4,8,… issued; decode sees pc 0x0,0x4,0x8 with matching words; first inst_valid 2 cycles after first request.
- inst_ready=0 for 10 cycles: exactly DEPTH=2 requests outstanding+buffered, imem_req_valid=0 afterwards; on release, pcs resume in order with no loss or duplication.
- Redirect to 0x100 while 2 requests are outstanding (latency 3): both stale responses dropped; next inst_pc=0x100, then 0x104.
- Redirect in the same cycle as a response and a pop: FIFO empty next cycle, response discarded, imem_addr=target next cycle.
- redirect_target=0x203: fetch at 0x200. Start at fetch_pc=0xFFFF_FFFC: next fetch address 0x0000_0000.
- IFETCH_PERF_EN defined, the redirect scenario above: perf_dropped=2, perf_fetched equals the number of instructions delivered plus flushed.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Constants shared by the fetch and decode stages: instruction width, RV32 major
// opcodes, the canonical NOP and the default reset PC.
package instr_fetch_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    function automatic logic [6:0] opcode_of(input logic [INST_W-1:0] inst);
        return inst[6:0];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect and
// the decode-side valid/ready instruction channel. master = fetch unit.
interface instr_fetch_if
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] instruction;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_target,
        output inst_valid, instruction, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_target,
        input  inst_valid, instruction, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} entries; clear has priority over
// push/pop, and push+pop on a full FIFO is accepted.
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         clear,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited word fetches, in-order response buffering and
// redirect flush. Define IFETCH_PERF_EN to add perf_fetched/perf_dropped counters.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_dropped
`endif
);
    localparam int               CNT_W   = $clog2(DEPTH+1);
    localparam int               ENTRY_W = INST_W + ADDR_W;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     credit_used;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               req_valid, req_fire, rsp_drop, push, pop;
    logic               unused_target_lsbs;

    assign unused_target_lsbs = ^bus.redirect_target[1:0];

    always_comb begin
        credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
        req_valid   = rst_n && !bus.redirect_valid && (credit_used < DEPTH_C);
        req_fire    = req_valid && bus.imem_req_ready;
        // A response landing in the redirect cycle belongs to the old stream.
        rsp_drop    = bus.imem_rsp_valid && ((drop_q != '0) || bus.redirect_valid);
        push        = bus.imem_rsp_valid && !rsp_drop;
        pop         = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
        redirect_pc = {bus.redirect_target[ADDR_W-1:2], 2'b00};

        outstanding_d = outstanding_q;
        if (req_fire)           outstanding_d = outstanding_d + CNT_W'(1);
        if (bus.imem_rsp_valid) outstanding_d = outstanding_d - CNT_W'(1);

        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
        if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        if (push)     rsp_pc_d   = rsp_pc_q + ADDR_W'(4);
        // Everything still in flight after a redirect is stale.
        if (bus.redirect_valid) begin
            drop_d     = outstanding_d;
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    always @(posedge clk) begin
        if (rst_n) assert (credit_used <= DEPTH_C);
    end

    instr_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({rsp_pc_q, bus.imem_rsp_data}),
        .pop       (pop),
        .clear     (bus.redirect_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = fetch_pc_q;
    assign bus.inst_valid     = (fifo_count != '0);
    assign bus.instruction    = bus.inst_valid ? fifo_head[INST_W-1:0] : '0;
    assign bus.inst_pc        = bus.inst_valid ? fifo_head[ENTRY_W-1:INST_W] : '0;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_dropped_q, perf_dropped_d;

    // Flushed entries count as dropped; a pop in the redirect cycle is ignored.
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(push);
        perf_dropped_d = perf_dropped_q + 32'(rsp_drop);
        if (bus.redirect_valid) perf_dropped_d = perf_dropped_d + 32'(fifo_count);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_dropped_q <= perf_dropped_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: fixed-latency memory model, decode monitor and
// hand-computed expectations (memory word = address ^ 32'hC0DE_0000).
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [31:0] K = 32'hC0DE_0000;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } dec_t;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          failures;
    int          lat;
    int          cyc;
    mreq_t       mq[$];
    dec_t        got[$];
    logic [31:0] req_log[$];

    instr_fetch_if #(.ADDR_W(32)) bus ();

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    instr_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model (in-order, fixed latency) plus request and decode logs.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        cyc = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mq.delete();
                got.delete();
                req_log.delete();
            end else begin
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    mq.push_back('{bus.imem_addr, cyc + lat});
                    req_log.push_back(bus.imem_addr);
                end
                if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid)
                    got.push_back('{bus.inst_pc, bus.instruction});
            end
            cyc++;
            #1;
            if (mq.size() > 0 && mq[0].due == cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mq[0].addr ^ K;
                void'(mq.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = '0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        lat = 1;
        rst_n = 1'b0;
        bus.inst_ready = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = '0;

        // Reset state
        repeat (3) step_cyc();
        at_neg();
        check("rst_req_valid", bus.imem_req_valid, 32'd0);
        check("rst_inst_valid", bus.inst_valid, 32'd0);
        check("rst_instruction", bus.instruction, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
`ifdef IFETCH_PERF_EN
        check("rst_perf_fetched", perf_fetched, 32'd0);
        check("rst_perf_dropped", perf_dropped, 32'd0);
`endif

        // Streaming, latency 1
        step_cyc(); rst_n = 1'b1;
        at_neg();
        check("c0_req_valid", bus.imem_req_valid, 32'd1);
        check("c0_addr", bus.imem_addr, 32'h0);
        check("c0_inst_valid", bus.inst_valid, 32'd0);
        step_cyc(); at_neg();
        check("c1_req_valid", bus.imem_req_valid, 32'd1);
        check("c1_addr", bus.imem_addr, 32'h4);
        check("c1_inst_valid", bus.inst_valid, 32'd0);
        step_cyc(); at_neg();
        check("c2_inst_valid", bus.inst_valid, 32'd1);
        check("c2_inst_pc", bus.inst_pc, 32'h0);
        check("c2_instruction", bus.instruction, 32'hC0DE_0000);
        check("c2_req_valid", bus.imem_req_valid, 32'd0);
        step_cyc(); at_neg();
        check("c3_inst_pc", bus.inst_pc, 32'h4);
        check("c3_instruction", bus.instruction, 32'hC0DE_0004);
        check("c3_addr", bus.imem_addr, 32'h8);
        repeat (6) step_cyc();

        // Decode stall for 10 cycles
        bus.inst_ready = 1'b0;
        repeat (10) step_cyc();
        at_neg();
        check("stall_req_valid", bus.imem_req_valid, 32'd0);
        check("stall_inst_valid", bus.inst_valid, 32'd1);
        check("stall_inflight", 32'(req_log.size() - got.size()), 32'd2);
        check("stall_head_pc", bus.inst_pc, 32'(4 * got.size()));
        step_cyc(); bus.inst_ready = 1'b1;
        repeat (12) step_cyc();
        bus.imem_req_ready = 1'b0;
        repeat (6) step_cyc();
        at_neg();
        check("seq_enough", 32'(got.size() >= 8), 32'd1);
        check("seq_no_loss", 32'(got.size()), 32'(req_log.size()));
        for (int i = 0; i < got.size(); i++) begin
            check($sformatf("seq_pc[%0d]", i), got[i].pc, 32'(4 * i));
            check($sformatf("seq_ins[%0d]", i), got[i].ins, 32'(4 * i) ^ K);
            check($sformatf("seq_req[%0d]", i), req_log[i], 32'(4 * i));
        end

        // Redirect with two stale requests in flight, latency 3
        step_cyc(); rst_n = 1'b0; lat = 3; bus.imem_req_ready = 1'b1;
        step_cyc(); at_neg();
        check("s3_rst_req_valid", bus.imem_req_valid, 32'd0);
        step_cyc(); rst_n = 1'b1;
        step_cyc();
        step_cyc(); bus.redirect_valid = 1'b1; bus.redirect_target = 32'h100;
        at_neg();
        check("s3_redir_req_valid", bus.imem_req_valid, 32'd0);
        step_cyc(); bus.redirect_valid = 1'b0;
        at_neg();
        check("s3_c3_req_valid", bus.imem_req_valid, 32'd0);
        step_cyc(); at_neg();
        check("s3_c4_req_valid", bus.imem_req_valid, 32'd1);
        check("s3_c4_addr", bus.imem_addr, 32'h100);
        step_cyc(); at_neg();
        check("s3_c5_addr", bus.imem_addr, 32'h104);
        repeat (3) step_cyc();
        at_neg();
        check("s3_c8_inst_valid", bus.inst_valid, 32'd1);
        check("s3_c8_inst_pc", bus.inst_pc, 32'h100);
        check("s3_c8_instruction", bus.instruction, 32'hC0DE_0100);
        step_cyc(); bus.imem_req_ready = 1'b0;
        at_neg();
        check("s3_c9_inst_pc", bus.inst_pc, 32'h104);
        check("s3_c9_instruction", bus.instruction, 32'hC0DE_0104);
`ifdef IFETCH_PERF_EN
        check("s3_perf_dropped", perf_dropped, 32'd2);
        check("s3_perf_fetched", perf_fetched, 32'd2);
`endif
        repeat (2) step_cyc();
        at_neg();
        check("s3_delivered", 32'(got.size()), 32'd2);
        check("s3_got0_pc", got[0].pc, 32'h100);
        check("s3_got1_pc", got[1].pc, 32'h104);

        // Fill the FIFO, then reset mid-operation
        step_cyc(); bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b0;
        repeat (8) step_cyc();
        at_neg();
        check("full_inst_valid", bus.inst_valid, 32'd1);
        check("full_inst_pc", bus.inst_pc, 32'h108);
        step_cyc(); rst_n = 1'b0; lat = 1; bus.inst_ready = 1'b1;
        step_cyc(); at_neg();
        check("midrst_inst_valid", bus.inst_valid, 32'd0);
        check("midrst_instruction", bus.instruction, 32'd0);
        check("midrst_inst_pc", bus.inst_pc, 32'd0);
`ifdef IFETCH_PERF_EN
        check("midrst_perf_fetched", perf_fetched, 32'd0);
        check("midrst_perf_dropped", perf_dropped, 32'd0);
`endif

        // Redirect coinciding with a response and a pop; unaligned target
        step_cyc(); rst_n = 1'b1;
        step_cyc();
        step_cyc(); bus.redirect_valid = 1'b1; bus.redirect_target = 32'h203;
        at_neg();
        check("s4_pre_inst_pc", bus.inst_pc, 32'h0);
        step_cyc(); bus.redirect_valid = 1'b0;
        at_neg();
        check("s4_flush_inst_valid", bus.inst_valid, 32'd0);
        check("s4_req_valid", bus.imem_req_valid, 32'd1);
        check("s4_target_addr", bus.imem_addr, 32'h200);
        check("s4_no_delivery", 32'(got.size()), 32'd0);
`ifdef IFETCH_PERF_EN
        check("s4_perf_dropped", perf_dropped, 32'd2);
        check("s4_perf_fetched", perf_fetched, 32'd1);
`endif
        step_cyc();
        step_cyc(); bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFF_FFFC;
        at_neg();
        check("s4_c5_inst_valid", bus.inst_valid, 32'd1);
        check("s4_c5_inst_pc", bus.inst_pc, 32'h200);
        check("s4_c5_instruction", bus.instruction, 32'hC0DE_0200);

        // Address wrap at the top of the address space
        step_cyc(); bus.redirect_valid = 1'b0;
        at_neg();
        check("wrap_c6_addr", bus.imem_addr, 32'hFFFF_FFFC);
        step_cyc(); at_neg();
        check("wrap_c7_req_valid", bus.imem_req_valid, 32'd1);
        check("wrap_c7_addr", bus.imem_addr, 32'h0000_0000);
        step_cyc(); at_neg();
        check("wrap_c8_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
        check("wrap_c8_instruction", bus.instruction, 32'h3F21_FFFC);

        // Back-to-back redirects, second one alongside a stale response
        step_cyc(); rst_n = 1'b0; lat = 3;
        step_cyc();
        step_cyc(); rst_n = 1'b1;
        step_cyc();
        step_cyc(); bus.redirect_valid = 1'b1; bus.redirect_target = 32'h300;
        step_cyc(); bus.redirect_target = 32'h400;
        at_neg();
        check("b2b_c3_req_valid", bus.imem_req_valid, 32'd0);
        step_cyc(); bus.redirect_valid = 1'b0;
        at_neg();
        check("b2b_c4_req_valid", bus.imem_req_valid, 32'd1);
        check("b2b_c4_addr", bus.imem_addr, 32'h400);
        step_cyc(); at_neg();
        check("b2b_c5_addr", bus.imem_addr, 32'h404);
        repeat (3) step_cyc();
        at_neg();
        check("b2b_c8_inst_valid", bus.inst_valid, 32'd1);
        check("b2b_c8_inst_pc", bus.inst_pc, 32'h400);
        check("b2b_c8_instruction", bus.instruction, 32'hC0DE_0400);
`ifdef IFETCH_PERF_EN
        check("b2b_perf_dropped", perf_dropped, 32'd2);
        check("b2b_perf_fetched", perf_fetched, 32'd1);
`endif
        step_cyc(); at_neg();
        check("b2b_c9_inst_pc", bus.inst_pc, 32'h404);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
